// File: rtl/psram_hyperbus_pkg.sv
// psram_hyperbus_pkg: shared definitions for the HyperBus PSRAM target.
//   - FSM state encodings (ST_IDLE..ST_REGWR)
//   - bit positions inside the 48-bit command/address word
//   - configuration register 0 reset default
//   - latency decode, skip-count and burst address advance helpers
package psram_hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LATENCY,
    ST_READ,
    ST_WRITE,
    ST_REGWR
  } state_t;

  // Command/address bit positions
  localparam int CA_RW_BIT       = 47;  // 1 = read
  localparam int CA_AS_BIT       = 46;  // 1 = register space
  localparam int CA_BURST_BIT    = 45;  // 0 = wrapped burst
  localparam int CA_ROW_HI       = 33;  // upper word address field [33:16]
  localparam int CA_ROW_LO       = 16;
  localparam int CA_COL_HI       = 2;   // lower word address field [2:0]
  localparam int CA_REG_CFG_BIT  = 24;  // 1 = configuration register
  localparam int CA_REG_SEL1_BIT = 0;   // 1 = register 1

  localparam logic [15:0] CFG0_RESET = 16'h8F1F;

  // cfg_reg0[7:4] latency code -> initial latency in CK cycles.
  function automatic logic [3:0] latency_decode(input logic [3:0] code,
                                                input logic [3:0] dflt);
    logic [3:0] lat;
    case (code)
      4'b0000: lat = 4'd5;
      4'b0001: lat = 4'd6;
      4'b1110: lat = 4'd3;
      4'b1111: lat = 4'd4;
      default: lat = dflt;
    endcase
    return lat;
  endfunction

  // Fixed 2x latency: number of CK rises skipped before the first data rise.
  function automatic logic [4:0] latency_skip(input logic [3:0] lat);
    return {lat, 1'b0} - 5'd1;
  endfunction

  // Wrapped bursts cycle within an 8-word (16-byte) group; linear bursts
  // roll over the whole 21-bit word space.
  function automatic logic [20:0] next_word_addr(input logic [20:0] addr,
                                                 input logic        wrapped);
    logic [20:0] nxt;
    if (wrapped) nxt = {addr[20:3], addr[2:0] + 3'd1};
    else         nxt = addr + 21'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/ip_psram_target_if.sv
// ip_psram_target_if: HyperBus pin bundle between an initiator and the target.
//   psram_ck, psram_cs_n, dq_in, rwds_in : initiator -> target
//   dq_out, dq_oe, rwds_out, rwds_oe     : target -> initiator (tristate halves)
// Modports: master = initiator side, slave = target side.
interface ip_psram_target_if;
  logic       psram_ck;
  logic       psram_cs_n;
  logic [7:0] dq_in;
  logic       rwds_in;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rwds_out;
  logic       rwds_oe;

  modport master (
    output psram_ck, psram_cs_n, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe
  );

  modport slave (
    input  psram_ck, psram_cs_n, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe
  );
endinterface

// File: rtl/ip_psram_target_sync.sv
// ip_psram_target_sync: 2-FF synchronisers for all HyperBus inputs plus
// CK rise/fall and CS rise/fall pulse detection in the clk domain.
// Ports:
//   clk, n_reset        system clock, asynchronous active-low reset
//   ck, cs_n, dq, rwds  raw bus inputs
//   dq_s, rwds_s        synchronised data/mask, aligned with the CK edge pulses
//   ck_rise, ck_fall    one-clk pulses per synchronised CK edge
//   cs_rise, cs_fall    one-clk pulses per synchronised CS_n edge
module ip_psram_target_sync (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ck,
  input  logic       cs_n,
  input  logic [7:0] dq,
  input  logic       rwds,
  output logic [7:0] dq_s,
  output logic       rwds_s,
  output logic       ck_rise,
  output logic       ck_fall,
  output logic       cs_rise,
  output logic       cs_fall
);

  localparam int W = 11;
  // CS_n resets deasserted so that a select already low at reset release
  // still produces a fall pulse.
  localparam logic [W-1:0] RST_VAL = {1'b0, 1'b1, 1'b0, 8'h00};

  logic [W-1:0] raw;
  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;
  logic         ck_d_reg;
  logic         cs_d_reg;

  assign raw = {ck, cs_n, rwds, dq};

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_sync
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          meta_reg[gi] <= RST_VAL[gi];
          sync_reg[gi] <= RST_VAL[gi];
        end else begin
          meta_reg[gi] <= raw[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ck_d_reg <= 1'b0;
      cs_d_reg <= 1'b1;
    end else begin
      ck_d_reg <= sync_reg[10];
      cs_d_reg <= sync_reg[9];
    end
  end

  assign dq_s    = sync_reg[7:0];
  assign rwds_s  = sync_reg[8];
  assign ck_rise =  sync_reg[10] & ~ck_d_reg;
  assign ck_fall = ~sync_reg[10] &  ck_d_reg;
  assign cs_rise =  sync_reg[9]  & ~cs_d_reg;
  assign cs_fall = ~sync_reg[9]  &  cs_d_reg;

endmodule

// File: rtl/ip_psram_target.sv
// ip_psram_target: HyperBus PSRAM device emulator. Decodes the 6-byte
// command/address, counts fixed 2x latency, serves read bursts from an
// external 16-bit word memory and accepts byte-masked write bursts and
// configuration register writes.
// Ports:
//   clk, n_reset      system clock (>= 4x bus CK), asynchronous active-low reset
//   bus (slave)       HyperBus pins: psram_ck, psram_cs_n, dq_in, rwds_in,
//                     dq_out, dq_oe, rwds_out, rwds_oe
//   mem_*             word memory port; mem_rdata valid 1 clk after mem_rd,
//                     [15:8] / mem_be[1] is the even (rising-edge) byte
//   cfg_reg0          configuration register 0
//   busy              high while a transaction is in progress
// Optional build macro PSRAM_TARGET_CFG_LATENCY_EN: latency is taken from
// cfg_reg0[7:4] at CA completion instead of the LATENCY parameter.
module ip_psram_target
  import psram_hyperbus_pkg::*;
#(
  parameter int          LATENCY      = 3,
  parameter logic [15:0] ID_REG0      = 16'h0C81,
  parameter logic [15:0] CFG0_DEFAULT = CFG0_RESET
) (
  input  logic               clk,
  input  logic               n_reset,
  ip_psram_target_if.slave   bus,
  output logic [20:0]        mem_address,
  output logic               mem_rd,
  input  logic [15:0]        mem_rdata,
  output logic               mem_wr,
  output logic [15:0]        mem_wdata,
  output logic [1:0]         mem_be,
  output logic [15:0]        cfg_reg0,
  output logic               busy
);

  localparam logic [3:0] LAT_DEFAULT = 4'(LATENCY);

  logic [7:0] dq_s;
  logic       rwds_s, ck_rise, ck_fall, cs_rise, cs_fall;

  ip_psram_target_sync u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .ck      (bus.psram_ck),
    .cs_n    (bus.psram_cs_n),
    .dq      (bus.dq_in),
    .rwds    (bus.rwds_in),
    .dq_s    (dq_s),
    .rwds_s  (rwds_s),
    .ck_rise (ck_rise),
    .ck_fall (ck_fall),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall)
  );

  state_t      state_reg, state_next;
  logic [39:0] ca_reg, ca_next;
  logic [2:0]  byte_cnt_reg, byte_cnt_next;
  logic [4:0]  lat_cnt_reg, lat_cnt_next;
  logic [4:0]  lat_skip_reg, lat_skip_next;
  logic [20:0] addr_reg, addr_next;
  logic        is_read_reg, is_read_next;
  logic        is_reg_reg, is_reg_next;
  logic        wrapped_reg, wrapped_next;
  logic        cfg0_sel_reg, cfg0_sel_next;
  logic        regwr_done_reg, regwr_done_next;
  logic [15:0] rd_word_reg, rd_word_next;
  logic        rd_pend_reg, rd_pend_next;
  logic [7:0]  hi_byte_reg, hi_byte_next;
  logic        hi_mask_reg, hi_mask_next;
  logic [7:0]  dq_out_reg, dq_out_next;
  logic        dq_oe_reg, dq_oe_next;
  logic        rwds_out_reg, rwds_out_next;
  logic        rwds_oe_reg, rwds_oe_next;
  logic        mem_rd_reg, mem_rd_next;
  logic        mem_wr_reg, mem_wr_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic [1:0]  mem_be_reg, mem_be_next;
  logic [15:0] cfg_reg, cfg_next;

  // Full CA word as it stands once the current byte is shifted in.
  logic [47:0] ca_full;
  logic [3:0]  lat_cycles;
  logic [15:0] reg_word;
  logic        unused_ca_bits;

  assign ca_full        = {ca_reg, dq_s};
  assign unused_ca_bits = ^{ca_full[44:34], ca_full[15:3]};

`ifdef PSRAM_TARGET_CFG_LATENCY_EN
  assign lat_cycles = latency_decode(cfg_reg[7:4], LAT_DEFAULT);
`else
  assign lat_cycles = LAT_DEFAULT;
`endif

  always_comb begin
    reg_word = 16'h0000;
    case ({ca_full[CA_REG_CFG_BIT], ca_full[CA_REG_SEL1_BIT]})
      2'b00:   reg_word = ID_REG0;
      2'b10:   reg_word = cfg_reg;
      default: reg_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    ca_next         = ca_reg;
    byte_cnt_next   = byte_cnt_reg;
    lat_cnt_next    = lat_cnt_reg;
    lat_skip_next   = lat_skip_reg;
    addr_next       = addr_reg;
    is_read_next    = is_read_reg;
    is_reg_next     = is_reg_reg;
    wrapped_next    = wrapped_reg;
    cfg0_sel_next   = cfg0_sel_reg;
    regwr_done_next = regwr_done_reg;
    rd_word_next    = rd_word_reg;
    rd_pend_next    = mem_rd_reg;
    hi_byte_next    = hi_byte_reg;
    hi_mask_next    = hi_mask_reg;
    dq_out_next     = dq_out_reg;
    dq_oe_next      = dq_oe_reg;
    rwds_out_next   = rwds_out_reg;
    rwds_oe_next    = rwds_oe_reg;
    mem_rd_next     = 1'b0;
    mem_wr_next     = 1'b0;
    mem_wdata_next  = mem_wdata_reg;
    mem_be_next     = mem_be_reg;
    cfg_next        = cfg_reg;

    if (rd_pend_reg) rd_word_next = mem_rdata;
    // The write strobe goes out with the current address; move on afterwards.
    if (mem_wr_reg) addr_next = next_word_addr(addr_reg, wrapped_reg);

    // CS rise aborts from any state and outranks a coincident CK edge.
    if (state_reg != ST_IDLE && cs_rise) begin
      state_next    = ST_IDLE;
      dq_oe_next    = 1'b0;
      rwds_oe_next  = 1'b0;
      rwds_out_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cs_fall) begin
            state_next    = ST_CA;
            byte_cnt_next = 3'd0;
            rwds_oe_next  = 1'b1;
            rwds_out_next = 1'b1;
          end
        end
        ST_CA: begin
          if (ck_rise || ck_fall) begin
            ca_next       = {ca_reg[31:0], dq_s};
            byte_cnt_next = byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == 3'd5) begin
              is_read_next    = ca_full[CA_RW_BIT];
              is_reg_next     = ca_full[CA_AS_BIT];
              wrapped_next    = !ca_full[CA_BURST_BIT];
              cfg0_sel_next   = ca_full[CA_REG_CFG_BIT] && !ca_full[CA_REG_SEL1_BIT];
              addr_next       = {ca_full[CA_ROW_HI:CA_ROW_LO], ca_full[CA_COL_HI:0]};
              lat_skip_next   = latency_skip(lat_cycles);
              lat_cnt_next    = 5'd0;
              regwr_done_next = 1'b0;
              rwds_out_next   = 1'b0;
              if (ca_full[CA_AS_BIT] && !ca_full[CA_RW_BIT]) begin
                state_next   = ST_REGWR;
                rwds_oe_next = 1'b0;
              end else begin
                state_next   = ST_LATENCY;
                rwds_oe_next = ca_full[CA_RW_BIT];
                if (ca_full[CA_RW_BIT] && !ca_full[CA_AS_BIT]) mem_rd_next  = 1'b1;
                if (ca_full[CA_RW_BIT] &&  ca_full[CA_AS_BIT]) rd_word_next = reg_word;
              end
            end
          end
        end
        ST_LATENCY: begin
          // The rise after the last skipped one carries the first data byte.
          if (ck_rise) begin
            if (lat_cnt_reg == lat_skip_reg) begin
              if (is_read_reg) begin
                state_next    = ST_READ;
                dq_oe_next    = 1'b1;
                rwds_oe_next  = 1'b1;
                dq_out_next   = rd_word_reg[15:8];
                rwds_out_next = 1'b1;
              end else begin
                state_next   = ST_WRITE;
                hi_byte_next = dq_s;
                hi_mask_next = rwds_s;
              end
            end else begin
              lat_cnt_next = lat_cnt_reg + 5'd1;
            end
          end
        end
        ST_READ: begin
          if (ck_rise) begin
            dq_out_next   = rd_word_reg[15:8];
            rwds_out_next = 1'b1;
          end else if (ck_fall) begin
            dq_out_next   = rd_word_reg[7:0];
            rwds_out_next = 1'b0;
            addr_next     = next_word_addr(addr_reg, wrapped_reg);
            if (!is_reg_reg) mem_rd_next = 1'b1;
          end
        end
        ST_WRITE: begin
          if (ck_rise) begin
            hi_byte_next = dq_s;
            hi_mask_next = rwds_s;
          end else if (ck_fall) begin
            mem_wr_next    = 1'b1;
            mem_wdata_next = {hi_byte_reg, dq_s};
            mem_be_next    = {~hi_mask_reg, ~rwds_s};
          end
        end
        ST_REGWR: begin
          // One data word only; later edges are ignored until CS rises.
          if (!regwr_done_reg) begin
            if (ck_rise) begin
              hi_byte_next = dq_s;
            end else if (ck_fall) begin
              if (cfg0_sel_reg) cfg_next = {hi_byte_reg, dq_s};
              regwr_done_next = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ca_reg         <= '0;
      byte_cnt_reg   <= '0;
      lat_cnt_reg    <= '0;
      lat_skip_reg   <= '0;
      addr_reg       <= '0;
      is_read_reg    <= 1'b0;
      is_reg_reg     <= 1'b0;
      wrapped_reg    <= 1'b0;
      cfg0_sel_reg   <= 1'b0;
      regwr_done_reg <= 1'b0;
      rd_word_reg    <= '0;
      rd_pend_reg    <= 1'b0;
      hi_byte_reg    <= '0;
      hi_mask_reg    <= 1'b0;
      dq_out_reg     <= '0;
      dq_oe_reg      <= 1'b0;
      rwds_out_reg   <= 1'b0;
      rwds_oe_reg    <= 1'b0;
      mem_rd_reg     <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= '0;
      cfg_reg        <= CFG0_DEFAULT;
    end else begin
      ca_reg         <= ca_next;
      byte_cnt_reg   <= byte_cnt_next;
      lat_cnt_reg    <= lat_cnt_next;
      lat_skip_reg   <= lat_skip_next;
      addr_reg       <= addr_next;
      is_read_reg    <= is_read_next;
      is_reg_reg     <= is_reg_next;
      wrapped_reg    <= wrapped_next;
      cfg0_sel_reg   <= cfg0_sel_next;
      regwr_done_reg <= regwr_done_next;
      rd_word_reg    <= rd_word_next;
      rd_pend_reg    <= rd_pend_next;
      hi_byte_reg    <= hi_byte_next;
      hi_mask_reg    <= hi_mask_next;
      dq_out_reg     <= dq_out_next;
      dq_oe_reg      <= dq_oe_next;
      rwds_out_reg   <= rwds_out_next;
      rwds_oe_reg    <= rwds_oe_next;
      mem_rd_reg     <= mem_rd_next;
      mem_wr_reg     <= mem_wr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_be_reg     <= mem_be_next;
      cfg_reg        <= cfg_next;
    end
  end

  assign bus.dq_out   = dq_out_reg;
  assign bus.dq_oe    = dq_oe_reg;
  assign bus.rwds_out = rwds_out_reg;
  assign bus.rwds_oe  = rwds_oe_reg;
  assign mem_address  = addr_reg;
  assign mem_rd       = mem_rd_reg;
  assign mem_wr       = mem_wr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_be       = mem_be_reg;
  assign cfg_reg0     = cfg_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule
